fir_tap_accumulator: RTL and testbench

Accumulates TAPS consecutive carry-save adder results (sum word plus carry-out) into one filtered ECG output sample. It sits directly downstream of the carry-save adder in the FIR datapath. The accumulated value is rounded, arithmetically scaled by SHIFT, and saturated (or wrapped) to OUT_W bits. The sample is presented on a valid/ready output port to the sample sink.

---
 rtl/fir_tap_accumulator.sv | 173 +++++++++++++++++
 tb/tb_fir_tap_accumulator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_accumulator.sv
// Accumulates TAPS carry-save adder beats into one rounded, scaled, clipped/wrapped sample.
// Latency: out_valid rises the cycle after the TAPS-th accepted beat; TAPS+1 cycles per sample minimum.
// Backpressure: in_ready drops while a sample waits on out_ready; the held sample never changes.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr                  synchronous abort of the partial accumulation (ignored while a sample is pending)
//   in_valid/in_ready    input beat handshake; in_ready is a flop
//   in_sum, in_cout      adder sum word (signed) and carry-out (diagnostic, ORed per sample)
//   out_valid/out_ready  output sample handshake
//   out_data             signed filtered sample
//   out_sat              sample was clipped (saturating build only)
//   out_carry            OR of in_cout over the sample's beats
//
// Build option: define FIR_ACC_SAT_EN to saturate out_data instead of wrapping it.
module fir_tap_accumulator #(
  parameter int TAPS  = 8,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_carry
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  // One guard bit above the TAPS-beat sum leaves room for the rounding constant.
  localparam int ACC_W = IN_W + $clog2(TAPS) + 1;

  localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT-1);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    carry_q, carry_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_carry_q, out_carry_d;

  logic signed [ACC_W-1:0] operand;
  logic signed [ACC_W-1:0] scaled;
  logic [OUT_W-1:0]        sample_data;
  logic                    sample_sat;
  logic                    accept;
  logic                    last_beat;

  assign operand = {{(ACC_W-IN_W){in_sum[IN_W-1]}}, in_sum};

  // Adding half an LSB before the arithmetic shift gives round-half-up.
  assign scaled = (acc_q + operand + RND) >>> SHIFT;

  // in_ready_q is only ever set in ST_ACC, so accept implies the accumulate state.
  assign accept    = in_valid && in_ready_q;
  assign last_beat = accept && (cnt_q == CNT_W'(TAPS-1));

`ifdef FIR_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    sample_data = scaled[OUT_W-1:0];
    sample_sat  = 1'b0;
    if (scaled > SAT_MAX) begin
      sample_data = {1'b0, {(OUT_W-1){1'b1}}};
      sample_sat  = 1'b1;
    end else if (scaled < SAT_MIN) begin
      sample_data = {1'b1, {(OUT_W-1){1'b0}}};
      sample_sat  = 1'b1;
    end
  end
`else
  // Wrap mode keeps only the low OUT_W bits; the upper bits are deliberately dropped.
  logic unused_scaled_hi;
  assign unused_scaled_hi = ^scaled[ACC_W-1:OUT_W];
  assign sample_data      = scaled[OUT_W-1:0];
  assign sample_sat       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_carry_d = out_carry_q;

    case (state_q)
      ST_ACC: begin
        if (clr) begin
          // Abort wins over a same-cycle beat; that beat is dropped.
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
        end else if (last_beat) begin
          acc_d       = '0;
          cnt_d       = '0;
          carry_d     = 1'b0;
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          out_data_d  = sample_data;
          out_sat_d   = sample_sat;
          out_carry_d = carry_q | in_cout;
        end else if (accept) begin
          acc_d   = acc_q + operand;
          cnt_d   = cnt_q + CNT_W'(1);
          carry_d = carry_q | in_cout;
        end
      end
      ST_OUT: begin
        // clr is not looked at here so a pending sample is never lost.
        if (out_valid_q && out_ready) begin
          state_d     = ST_ACC;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase

    // Registered ready: follows the state being entered, so it rises one cycle after reset
    // release and one cycle after an output handshake.
    in_ready_d = (state_d == ST_ACC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_carry_q <= out_carry_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_carry = out_carry_q;

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Bench for fir_tap_accumulator with TAPS=4, IN_W=32, OUT_W=16, SHIFT=15.
// Directed vector table, multi-cycle corner sequences, then random samples against a reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fir_tap_accumulator;

  typedef logic [3:0][31:0] beats_t;

  typedef struct {
    beats_t      b;
    logic [3:0]  c;
    logic [15:0] d;
    logic        s;
    logic        cy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic        in_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_carry;

  int n_tests = 0;
  int n_fail  = 0;

  fir_tap_accumulator #(
    .TAPS (4),
    .IN_W (32),
    .OUT_W(16),
    .SHIFT(15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_cout  (in_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beats_t mk(input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3);
    beats_t r;
    r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3;
    return r;
  endfunction

  // Reference: exact integer sum, add half an output LSB, floor-divide by 2^15, then clip or wrap.
  function automatic void ref_model(input beats_t b, input logic [3:0] c,
                                    output logic [15:0] d, output logic s, output logic cy);
    longint      sum;
    longint      q;
    logic [63:0] qb;
    sum = 0;
    for (int i = 0; i < 4; i++) sum += longint'($signed(b[i]));
    sum += 16384;
    q = sum / 32768;
    if (sum < 0 && (sum % 32768) != 0) q = q - 1;
    s = 1'b0;
`ifdef FIR_ACC_SAT_EN
    if (q > 32767) begin
      q = 32767; s = 1'b1;
    end else if (q < -32768) begin
      q = -32768; s = 1'b1;
    end
`endif
    qb = q;
    d  = qb[15:0];
    cy = |c;
  endfunction

  function automatic logic [31:0] rnd_beat();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(3, 0))
      0:       return r;
      1:       return {{16{r[15]}}, r[15:0]};
      2:       return {{8{r[23]}}, r[23:0]};
      default: return {r[31], r[31], r[29:0]};
    endcase
  endfunction

  // Presents one beat and returns on the falling edge after it was accepted.
  task automatic put_beat(input logic [31:0] v, input logic co);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sum   = v;
    in_cout  = co;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_cout = 1'b0;
  endtask

  // Sends one sample's beats with random gaps, holds out_ready low for 'hold' cycles,
  // checks latency, stability and the handshake, and returns what the DUT produced.
  task automatic run_sample(input beats_t b, input logic [3:0] c, input int gap_max,
                            input int hold, output logic [15:0] d, output logic s,
                            output logic cy);
    out_ready = (hold == 0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        in_valid = 1'b0;
        in_sum   = $urandom;
        @(negedge clk);
      end
      put_beat(b[i], c[i]);
      if (i < 3) check($sformatf("early_valid_beat%0d", i), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    in_sum   = $urandom;
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("ready_low_in_out", 32'(in_ready), 32'd0);
    d  = out_data;
    s  = out_sat;
    cy = out_carry;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_sum   = $urandom;
      in_cout  = 1'b1;
      clr      = 1'($urandom_range(1, 0));
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_data", {15'd0, out_sat, out_data}, {15'd0, s, d});
      check("hold_carry", 32'(out_carry), 32'(cy));
    end
    in_valid  = 1'b0;
    in_cout   = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  vec_t        vecs[6];
  logic [15:0] got_d, exp_d;
  logic        got_s, exp_s, got_cy, exp_cy;
  beats_t      bb;
  logic [3:0]  cc;

  initial begin
    vecs[0] = '{b: mk(32'h00004000, 32'h00004000, 32'h00004000, 32'h00004000), c: 4'b0000,
                d: 16'h0002, s: 1'b0, cy: 1'b0};
    vecs[1] = '{b: mk(32'h00004000, 32'h0, 32'h0, 32'h0), c: 4'b0010,
                d: 16'h0001, s: 1'b0, cy: 1'b1};
    vecs[2] = '{b: mk(32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000), c: 4'b0000,
                d: 16'hFFFC, s: 1'b0, cy: 1'b0};
`ifdef FIR_ACC_SAT_EN
    vecs[3] = '{b: mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000), c: 4'b0000,
                d: 16'h7FFF, s: 1'b1, cy: 1'b0};
`else
    vecs[3] = '{b: mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000), c: 4'b0000,
                d: 16'h0000, s: 1'b0, cy: 1'b0};
`endif
    // -0.5 LSB rounds up to zero; carry on the last beat alone still reports.
    vecs[4] = '{b: mk(32'hFFFFC000, 32'h0, 32'h0, 32'h0), c: 4'b1000,
                d: 16'h0000, s: 1'b0, cy: 1'b1};
    vecs[5] = '{b: mk(32'h0, 32'h0, 32'h0, 32'h0), c: 4'b0000,
                d: 16'h0000, s: 1'b0, cy: 1'b0};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", {14'd0, out_sat, out_carry, out_data}, 32'd0);
    rst_n = 1'b1;
    check("rel_ready_not_yet", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_rises", 32'(in_ready), 32'd1);

    // Directed table, out_ready held high, back-to-back beats.
    for (int i = 0; i < 6; i++) begin
      run_sample(vecs[i].b, vecs[i].c, 0, 0, got_d, got_s, got_cy);
      check($sformatf("vec%0d_data", i), 32'(got_d), 32'(vecs[i].d));
      check($sformatf("vec%0d_sat", i), 32'(got_s), 32'(vecs[i].s));
      check($sformatf("vec%0d_carry", i), 32'(got_cy), 32'(vecs[i].cy));
    end

    // Backpressure for 5 cycles with in_valid and clr toggling during the hold.
    run_sample(vecs[0].b, 4'b0100, 0, 5, got_d, got_s, got_cy);
    check("bp_data", 32'(got_d), 32'h0002);
    check("bp_carry", 32'(got_cy), 32'd1);

    // clr together with the 3rd beat: the sample restarts from the next beat.
    put_beat(32'h00004000, 1'b0);
    put_beat(32'h00004000, 1'b1);
    clr = 1'b1; in_valid = 1'b1; in_sum = 32'h7FFF0000; in_cout = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; in_cout = 1'b0;
    check("clr_no_valid", 32'(out_valid), 32'd0);
    run_sample(mk(32'h8000, 32'h8000, 32'h8000, 32'h8000), 4'b0000, 0, 0, got_d, got_s, got_cy);
    check("clr_fresh_data", 32'(got_d), 32'h0004);
    check("clr_fresh_carry", 32'(got_cy), 32'd0);

    // Asynchronous reset after two beats.
    put_beat(32'h40000000, 1'b1);
    put_beat(32'h40000000, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc_ready", 32'(in_ready), 32'd0);
    check("arst_acc_outs", {14'd0, out_valid, out_carry, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_acc_ready_back", 32'(in_ready), 32'd1);
    run_sample(vecs[0].b, 4'b0000, 0, 0, got_d, got_s, got_cy);
    check("arst_acc_fresh_data", 32'(got_d), 32'h0002);
    check("arst_acc_fresh_carry", 32'(got_cy), 32'd0);

    // Asynchronous reset while a sample is pending.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put_beat(32'h00C00000, 1'b1);
    in_valid = 1'b0;
    check("arst_out_pending", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_cleared", {13'd0, out_valid, out_sat, out_carry, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sample(vecs[1].b, vecs[1].c, 0, 0, got_d, got_s, got_cy);
    check("arst_out_fresh_data", 32'(got_d), 32'h0001);

    // Random samples with gaps and backpressure against the reference model.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) bb[i] = rnd_beat();
      cc = 4'($urandom);
      ref_model(bb, cc, exp_d, exp_s, exp_cy);
      run_sample(bb, cc, 2, $urandom_range(3, 0), got_d, got_s, got_cy);
      check($sformatf("rnd%0d_data", n), 32'(got_d), 32'(exp_d));
      check($sformatf("rnd%0d_sat", n), 32'(got_s), 32'(exp_s));
      check($sformatf("rnd%0d_carry", n), 32'(got_cy), 32'(exp_cy));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
